mem_responder: RTL and testbench



---
 rtl/mem_responder.sv | 182 ++++++++++++++++++
 tb/tb_mem_responder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder
//   Single-port word memory answering the core's memory request interface.
//   It accepts one request at a time, waits LATENCY cycles, performs the
//   access and pulses mem_resp for exactly one cycle. Misaligned requests and
//   requests with both read and write asserted are flagged with mem_err.
//
// Parameters
//   DEPTH      number of 32-bit words (power of two, >= 2)
//   LATENCY    request-sample edge to mem_resp, 1..15 cycles
//   INIT_FILE  hex image name; contents start undefined
//
// Ports
//   clk        clock
//   rst        synchronous active-high reset
//   mem_read   read request, held until mem_resp
//   mem_write  write request, held until mem_resp
//   mem_addr   byte address (upper bits beyond the array alias)
//   mem_wdata  write data
//   mem_rdata  read data, valid while mem_resp=1 (pre-write data on writes)
//   mem_resp   one-cycle completion pulse
//   mem_err    error qualifier, valid while mem_resp=1
//   busy       high whenever the FSM is not IDLE
module mem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_err,
  output logic        busy
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned LAW    = AW + 2;  // byte-address bits that matter
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [LAW-1:0]   addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             resp_q, resp_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic [31:0]      mem [DEPTH];

  // Access view used on the edge entering RESP: straight from the inputs when
  // LATENCY=1 (IDLE jumps to RESP), otherwise from the latched request.
  logic             enter_resp;
  logic [LAW-1:0]   acc_addr;
  logic [31:0]      acc_wdata;
  logic             acc_rd;
  logic             acc_wr;
  logic [AW-1:0]    acc_idx;

  // Upper address bits alias by design; they are deliberately unused.
  logic             unused_addr_hi;
  assign unused_addr_hi = ^mem_addr[31:LAW];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    rdata_d    = rdata_q;
    resp_d     = 1'b0;
    err_d      = 1'b0;
    enter_resp = 1'b0;
    acc_addr   = addr_q;
    acc_wdata  = wdata_q;
    acc_rd     = rd_q;
    acc_wr     = wr_q;

    unique case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          addr_d    = mem_addr[LAW-1:0];
          wdata_d   = mem_wdata;
          rd_d      = mem_read;
          wr_d      = mem_write;
          cnt_d     = LAT_M1;
          acc_addr  = mem_addr[LAW-1:0];
          acc_wdata = mem_wdata;
          acc_rd    = mem_read;
          acc_wr    = mem_write;
          if (LATENCY == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        // Request inputs are still held by the core here and are ignored.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    acc_idx = acc_addr[2 +: AW];

    if (enter_resp) begin
      resp_d  = 1'b1;
      rdata_d = mem[acc_idx];  // read-before-write on writes
      err_d   = (acc_addr[1:0] != 2'b00) || (acc_rd && acc_wr);
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // NOTE: the array has no reset; clearing it would block RAM inference and
  // its contents must survive rst. Reset still suppresses a pending write.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && acc_wr) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_resp  = resp_q;
  assign mem_err   = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder. Three instances (LATENCY 2, 1, 4) share
// clock and reset; each has its own request/response signals.
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic        rd     [3];
  logic        wr     [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic [31:0] rdata_o[3];
  logic        resp_o [3];
  logic        err_o  [3];
  logic        busy_o [3];

  int lat_of [3] = '{2, 1, 4};

  int n_pass  = 0;
  int n_total = 0;

  mem_responder #(.DEPTH(1024), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst),
    .mem_read(rd[0]), .mem_write(wr[0]), .mem_addr(addr[0]), .mem_wdata(wdata[0]),
    .mem_rdata(rdata_o[0]), .mem_resp(resp_o[0]), .mem_err(err_o[0]), .busy(busy_o[0])
  );

  mem_responder #(.DEPTH(1024), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst),
    .mem_read(rd[1]), .mem_write(wr[1]), .mem_addr(addr[1]), .mem_wdata(wdata[1]),
    .mem_rdata(rdata_o[1]), .mem_resp(resp_o[1]), .mem_err(err_o[1]), .busy(busy_o[1])
  );

  mem_responder #(.DEPTH(1024), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst),
    .mem_read(rd[2]), .mem_write(wr[2]), .mem_addr(addr[2]), .mem_wdata(wdata[2]),
    .mem_rdata(rdata_o[2]), .mem_resp(resp_o[2]), .mem_err(err_o[2]), .busy(busy_o[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issue one request on unit u and follow it to completion.
  task automatic do_req(input int u, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic chk_data, input logic [31:0] exp_d,
                        input logic exp_e, input string tag);
    int  n;
    bit  seen;
    @(posedge clk); #1;
    rd[u] = r; wr[u] = w; addr[u] = a; wdata[u] = d;
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (n == 1 && lat_of[u] > 1) check({tag, "_busy_wait"}, 32'(busy_o[u]), 32'd1);
      if (resp_o[u]) seen = 1;
    end
    rd[u] = 1'b0; wr[u] = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'(lat_of[u]));
    if (chk_data) check({tag, "_rdata"}, rdata_o[u], exp_d);
    check({tag, "_err"}, 32'(err_o[u]), 32'(exp_e));
    @(posedge clk); #1;
    check({tag, "_resp_one_cycle"}, 32'(resp_o[u]), 32'd0);
    check({tag, "_busy_after"}, 32'(busy_o[u]), 32'd0);
    check({tag, "_err_after"}, 32'(err_o[u]), 32'd0);
  endtask

  initial begin
    int pulses;
    for (int i = 0; i < 3; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_resp_%0d", i),  32'(resp_o[i]), 32'd0);
      check($sformatf("reset_err_%0d", i),   32'(err_o[i]),  32'd0);
      check($sformatf("reset_busy_%0d", i),  32'(busy_o[i]), 32'd0);
      check($sformatf("reset_rdata_%0d", i), rdata_o[i],     32'd0);
    end
    rst = 1'b0;

    // LATENCY=2 write then read back.
    do_req(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, "l2_wr40");
    do_req(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, "l2_rd40");

    // LATENCY=1 with address aliasing modulo 4 KiB.
    do_req(1, 1'b0, 1'b1, 32'h0, 32'h1234, 1'b0, 32'h0, 1'b0, "l1_wr0");
    do_req(1, 1'b1, 1'b0, 32'h1000, 32'h0, 1'b1, 32'h1234, 1'b0, "l1_rd1000");

    // Read+write together: read-before-write data and error.
    do_req(0, 1'b0, 1'b1, 32'h8, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0, "l2_wr8");
    do_req(0, 1'b1, 1'b1, 32'h8, 32'h5A5A5A5A, 1'b1, 32'hA5A5A5A5, 1'b1, "l2_rw8");
    do_req(0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 32'h5A5A5A5A, 1'b0, "l2_rd8");

    // Misaligned read still uses the word index.
    do_req(0, 1'b0, 1'b1, 32'h40, 32'h77, 1'b0, 32'h0, 1'b0, "l2_wr40b");
    do_req(0, 1'b1, 1'b0, 32'h43, 32'h0, 1'b1, 32'h77, 1'b1, "l2_rd43");

    // LATENCY=4: reset during WAIT aborts the write.
    do_req(2, 1'b0, 1'b1, 32'h10, 32'hCAFE0000, 1'b0, 32'h0, 1'b0, "l4_wr10");
    @(posedge clk); #1;
    wr[2] = 1'b1; addr[2] = 32'h10; wdata[2] = 32'h1;
    @(posedge clk); #1;           // sampling edge
    @(posedge clk); #1;
    rst = 1'b1; wr[2] = 1'b0;
    @(posedge clk); #1;           // reset edge, FSM was in WAIT
    check("abort_busy", 32'(busy_o[2]), 32'd0);
    check("abort_resp", 32'(resp_o[2]), 32'd0);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (resp_o[2]) pulses++;
    end
    check("abort_no_resp", 32'(pulses), 32'd0);
    do_req(2, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 32'hCAFE0000, 1'b0, "l4_rd10_after_abort");

    // LATENCY=4: reset on the edge entering RESP wins.
    do_req(2, 1'b0, 1'b1, 32'h14, 32'hBEEF0001, 1'b0, 32'h0, 1'b0, "l4_wr14");
    @(posedge clk); #1;
    wr[2] = 1'b1; addr[2] = 32'h14; wdata[2] = 32'h2;
    @(posedge clk); #1;           // sampling edge, counter 3
    @(posedge clk); #1;           // counter 2
    @(posedge clk); #1;           // counter 1
    rst = 1'b1; wr[2] = 1'b0;
    @(posedge clk); #1;           // would have entered RESP
    check("rstresp_resp", 32'(resp_o[2]), 32'd0);
    check("rstresp_rdata", rdata_o[2], 32'd0);
    check("rstresp_busy", 32'(busy_o[2]), 32'd0);
    rst = 1'b0;
    do_req(2, 1'b1, 1'b0, 32'h14, 32'h0, 1'b1, 32'hBEEF0001, 1'b0, "l4_rd14_after_rst");

    // Continuous read on LATENCY=2: responses every 3 cycles, WAIT-time
    // address changes ignored.
    do_req(0, 1'b0, 1'b1, 32'h20, 32'h11, 1'b0, 32'h0, 1'b0, "l2_wr20");
    do_req(0, 1'b0, 1'b1, 32'h24, 32'h22, 1'b0, 32'h0, 1'b0, "l2_wr24");
    do_req(0, 1'b0, 1'b1, 32'h28, 32'h33, 1'b0, 32'h0, 1'b0, "l2_wr28");
    @(posedge clk); #1;
    rd[0] = 1'b1; addr[0] = 32'h20;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      check($sformatf("stream_resp_c%0d", c), 32'(resp_o[0]),
            32'((c == 2) || (c == 5) || (c == 8)));
      case (c)
        1: addr[0] = 32'h28;                                  // WAIT, ignored
        2: begin check("stream_rdata_0", rdata_o[0], 32'h11); addr[0] = 32'h24; end
        4: addr[0] = 32'h20;                                  // WAIT, ignored
        5: begin check("stream_rdata_1", rdata_o[0], 32'h22); addr[0] = 32'h28; end
        7: addr[0] = 32'h24;                                  // WAIT, ignored
        8: begin check("stream_rdata_2", rdata_o[0], 32'h33); rd[0] = 1'b0; end
        default: ;
      endcase
    end
    @(posedge clk); #1;
    check("stream_end_busy", 32'(busy_o[0]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
